mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one pipelined, fixed-latency single-port memory between instruction fetch (I) and data load/store (D).
//  Sits between Core's IMEM/DMEM request lines and a unified SRAM.
//  Arbitrates one issue per cycle: D has priority, with an anti-starvation bound for I.
//  Routes read data back to the owning requester and produces the fetch stall consumed by the pipeline controller.
// PARAMETERS
//  ADDR_W       32  address width
//  DATA_W       32  data width
//  MEM_LATENCY  1   cycles from mem_en to mem_rdata valid; range 1..4
//  STARVE_MAX   3   consecutive D grants while I waits before I is forced; range 1..15
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-high
//  ena          in   1       0: no new grants; in-flight responses still return
//  i_req        in   1       fetch request, held until granted
//  i_addr       in   ADDR_W  fetch address
//  i_flush      in   1       branch redirect: discard all in-flight fetch responses
//  i_gnt        out  1       fetch accepted this cycle (combinational)
//  i_stall      out  1       i_req & ~i_gnt
//  i_rvalid     out  1       fetch data valid
//  i_rdata      out  DATA_W  fetch data
//  d_req        in   1       data request, held until granted
//  d_we         in   1       1 = store
//  d_addr       in   ADDR_W  data address
//  d_wdata      in   DATA_W  store data
//  d_gnt        out  1       data accepted this cycle (combinational)
//  d_rvalid     out  1       load data valid; never asserted for stores
//  d_rdata      out  DATA_W  load data
//  mem_en       out  1       memory access this cycle
//  mem_we       out  1       memory write
//  mem_addr     out  ADDR_W  memory address
//  mem_wdata    out  DATA_W  memory write data
//  mem_rdata    in   DATA_W  valid MEM_LATENCY cycles after a read issue
// BEHAVIOUR
//  - Grant, combinational, evaluated each cycle with ena=1:
//    - D wins if d_req and (starve_cnt < STARVE_MAX or ~i_req).
//    - Otherwise I wins if i_req.
//    - ena=0: i_gnt = d_gnt = mem_en = 0.
//  - Memory outputs mux the granted requester; mem_we = d_gnt & d_we; mem_wdata = d_wdata.
//    Outputs are 0 when idle.
//  - starve_cnt (4b register):
//    - +1 on a D grant while i_req=1.
//    - Clears on an I grant or when i_req=0.
//    - Saturates at STARVE_MAX.
//  - Tag pipe: MEM_LATENCY-stage shift register of {valid, owner}. Stage 0 is loaded on every non-write grant.
//  - Response: the last stage's valid & owner selects i_rvalid or d_rvalid. rdata outputs are mem_rdata passthrough.
//  - Latency is exactly MEM_LATENCY cycles. Back-to-back issue every cycle is allowed.
//  - i_flush=1 clears valid on all I-owned tags, including the one loaded that cycle and the one responding that cycle.
//    It also masks i_rvalid in the same cycle. D tags are unaffected.
//  - A fetch grant in the same cycle as i_flush is still issued to memory, but its response is dropped.
//  - Simultaneous i_req & d_req with starve_cnt==STARVE_MAX: I granted, counter clears, D stalls one cycle.
//  - Reset (async, any time):
//    - Tags, starve_cnt, rvalids and all registered state go to 0.
//    - In-flight responses are dropped.
//    - Grant and memory outputs are 0 while reset is high.
//  - No request buffering: requesters hold their requests; the arbiter never drops an ungranted request.
// STRUCTURE
//  - mem_arb_pkg: owner_t enum {OWN_I, OWN_D}; tag_t struct {valid, owner}; STARVE_CNT_W = 4.
//  - Sub-module arb_tag_pipe: parameterised tag shift register with async reset and owner-selective flush.
//  - Top level holds grant logic, starvation counter and response routing.
// TESTING
//  1 - Reset, then i_req=1 with addr 0x100 for 3 cycles, MEM_LATENCY=1:
//      i_gnt every cycle; i_rvalid at cycles 2..4 carrying data for 0x100.
//  2 - i_req and d_req both held 5 cycles, STARVE_MAX=3:
//      grants D,D,D,I,D; i_stall=1 on cycles 1..3.
//  3 - d_req store (d_we=1) to 0x40 with 0xDEADBEEF, then load from 0x40:
//      mem_we=1 on cycle 1; no d_rvalid for the store; d_rvalid with 0xDEADBEEF MEM_LATENCY cycles after the load grant.
//  4 - MEM_LATENCY=3, fetch issued on cycles 1..3, i_flush at cycle 3:
//      no i_rvalid at cycles 3..6; an interleaved D load still returns d_rvalid.
//  5 - Async reset asserted mid-cycle with 2 responses in flight:
//      outputs go to 0 immediately; no rvalid after release; first request after release granted normally.
//  6 - ena=0 with both requests pending:
//      no grants, i_stall=1; outstanding responses still delivered.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D memory port arbiter: tag owner, tag record, counter width.
package mem_arb_pkg;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } tag_t;

    localparam int STARVE_CNT_W = 4;

    // A branch redirect kills fetch tags only; data tags pass through untouched.
    function automatic tag_t flush_tag(tag_t t, logic flush);
        tag_t r;
        r = t;
        if (flush && t.owner == OWN_I) r.valid = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side request/response lines and unified SRAM lines of the I/D memory port arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ena;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_flush;
    logic              i_gnt;
    logic              i_stall;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ena, i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_stall, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output ena, i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_stall, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/arb_tag_pipe.sv
// Fixed-depth shift register of {valid, owner} tags tracking reads in flight to the SRAM,
// with a flush that drops fetch-owned tags at every stage including the incoming one.
module arb_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  tag_t tag_i,
    input  logic flush_i,
    output tag_t tag_o
);
    tag_t stage_q [DEPTH];
    tag_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = flush_tag(tag_i, flush_i);
        for (int k = 1; k < DEPTH; k++) begin
            stage_d[k] = flush_tag(stage_q[k-1], flush_i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_o = stage_q[DEPTH-1];
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port SRAM between fetch (I) and load/store (D):
// D-priority grant with a starvation bound for I, and tag-based read-data routing.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1,
    parameter int STARVE_MAX  = 3
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] starve_q, starve_d;
    logic                    d_win, i_win;
    logic [ADDR_W-1:0]       addr_mux;
    logic [DATA_W-1:0]       wdata_mux;
    tag_t                    tag_in, tag_out;

    // Grants are forced low while reset is high, not just after the next edge.
    always_comb begin
        d_win = bus.ena & ~reset & bus.d_req & ((starve_q < STARVE_LIM) | ~bus.i_req);
        i_win = bus.ena & ~reset & bus.i_req & ~d_win;
    end

    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        if (d_win) begin
            addr_mux  = bus.d_addr;
            wdata_mux = bus.d_wdata;
        end else if (i_win) begin
            addr_mux = bus.i_addr;
        end
    end

    assign bus.i_gnt     = i_win;
    assign bus.d_gnt     = d_win;
    assign bus.i_stall   = bus.i_req & ~i_win;
    assign bus.mem_en    = i_win | d_win;
    assign bus.mem_we    = d_win & bus.d_we;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;

    always_comb begin
        starve_d = starve_q;
        if (~bus.i_req | i_win) begin
            starve_d = '0;
        end else if (d_win && starve_q < STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) starve_q <= '0;
        else       starve_q <= starve_d;
    end

    // Stores produce no response, so only read issues enter the tag pipe.
    always_comb begin
        tag_in.valid = (i_win | d_win) & ~(d_win & bus.d_we);
        tag_in.owner = d_win ? OWN_D : OWN_I;
    end

    arb_tag_pipe #(
        .DEPTH (MEM_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_i   (tag_in),
        .flush_i (bus.i_flush),
        .tag_o   (tag_out)
    );

    assign bus.i_rvalid = tag_out.valid & (tag_out.owner == OWN_I) & ~bus.i_flush;
    assign bus.d_rvalid = tag_out.valid & (tag_out.owner == OWN_D);
    assign bus.i_rdata  = bus.mem_rdata;
    assign bus.d_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a fixed-latency SRAM model (latency 3, starvation bound 3).
module tb_mem_port_arbiter;
    localparam int LAT = 3;
    localparam int SM  = 3;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cnt = 0;

    exp_t iq[$];
    exp_t dq[$];

    bit [31:0] mem     [256];
    bit        mem_wr  [256];
    bit [31:0] ref_mem [256];
    bit        ref_wr  [256];
    bit [31:0] dl      [LAT];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MEM_LATENCY (LAT),
        .STARVE_MAX  (SM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_wr[a[9:2]] ? ref_mem[a[9:2]] : pat({22'd0, a[9:2], 2'b00});
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // SRAM model: reads return MEM_LATENCY cycles after issue.
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) dl[k] <= dl[k-1];
        if (bus.mem_en && !bus.mem_we)
            dl[0] <= mem_wr[bus.mem_addr[9:2]] ? mem[bus.mem_addr[9:2]]
                                               : pat({22'd0, bus.mem_addr[9:2], 2'b00});
        else
            dl[0] <= 32'h0;
        if (bus.mem_en && bus.mem_we) begin
            mem[bus.mem_addr[9:2]]    <= bus.mem_wdata;
            mem_wr[bus.mem_addr[9:2]] <= 1'b1;
        end
    end
    assign bus.mem_rdata = dl[LAT-1];

    always @(negedge clk) begin : monitor
        logic exp_iv, exp_dv, exp_i, exp_d;
        if (reset) begin
            iq.delete();
            dq.delete();
            cnt = 0;
            chk("rst_i_rvalid", bus.i_rvalid, 0);
            chk("rst_d_rvalid", bus.d_rvalid, 0);
            chk("rst_mem_en", bus.mem_en, 0);
            chk("rst_i_gnt", bus.i_gnt, 0);
            chk("rst_d_gnt", bus.d_gnt, 0);
        end else begin
            if (bus.i_flush) iq.delete();
            exp_iv = (iq.size() != 0) && (iq[0].due == cyc);
            chk("i_rvalid", bus.i_rvalid, exp_iv);
            if (exp_iv) begin
                chk("i_rdata", bus.i_rdata, iq[0].data);
                void'(iq.pop_front());
            end
            exp_dv = (dq.size() != 0) && (dq[0].due == cyc);
            chk("d_rvalid", bus.d_rvalid, exp_dv);
            if (exp_dv) begin
                chk("d_rdata", bus.d_rdata, dq[0].data);
                void'(dq.pop_front());
            end

            exp_d = bus.ena & bus.d_req & ((cnt < SM) | ~bus.i_req);
            exp_i = bus.ena & bus.i_req & ~exp_d;
            chk("d_gnt", bus.d_gnt, exp_d);
            chk("i_gnt", bus.i_gnt, exp_i);
            chk("i_stall", bus.i_stall, bus.i_req & ~exp_i);
            chk("mem_en", bus.mem_en, exp_i | exp_d);
            chk("mem_we", bus.mem_we, exp_d & bus.d_we);
            if (exp_i | exp_d)
                chk("mem_addr", bus.mem_addr, exp_d ? bus.d_addr : bus.i_addr);
            if (exp_d && bus.d_we) begin
                chk("mem_wdata", bus.mem_wdata, bus.d_wdata);
                ref_mem[bus.d_addr[9:2]] = bus.d_wdata;
                ref_wr[bus.d_addr[9:2]]  = 1'b1;
            end
            if (exp_d && !bus.d_we) dq.push_back('{ref_rd(bus.d_addr), cyc + LAT});
            if (exp_i && !bus.i_flush) iq.push_back('{ref_rd(bus.i_addr), cyc + LAT});

            if (!bus.i_req || exp_i) cnt = 0;
            else if (exp_d && cnt < SM) cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        bus.i_req   = 1'b0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.i_flush = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit exp_d2 [5];
        exp_d2 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        reset       = 1'b1;
        bus.ena     = 1'b1;
        bus.i_addr  = 32'h0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        idle_reqs();
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        repeat (2) tick();
        idle_reqs();
        reset = 1'b0;
        tick();

        // Back-to-back fetches.
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h100;
        for (int k = 0; k < 3; k++) begin
            #1 chk("t1_i_gnt", bus.i_gnt, 1);
            chk("t1_mem_addr", bus.mem_addr, 32'h100);
            tick();
        end
        idle_reqs();
        repeat (LAT + 1) tick();

        // Contention: D priority with forced I after SM D grants.
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h104;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h80;
        for (int k = 0; k < 5; k++) begin
            #1 chk("t2_d_gnt", bus.d_gnt, exp_d2[k]);
            chk("t2_i_gnt", bus.i_gnt, !exp_d2[k]);
            chk("t2_i_stall", bus.i_stall, exp_d2[k]);
            tick();
        end
        idle_reqs();
        repeat (LAT + 1) tick();

        // Store then load of the same word.
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h40;
        bus.d_wdata = 32'hDEADBEEF;
        #1 chk("t3_mem_we", bus.mem_we, 1);
        chk("t3_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        tick();
        bus.d_we = 1'b0;
        #1 chk("t3_ld_mem_we", bus.mem_we, 0);
        chk("t3_ld_d_gnt", bus.d_gnt, 1);
        tick();
        idle_reqs();
        repeat (LAT + 1) tick();

        // Fetch flush with an interleaved data load still in flight.
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h200;
        tick();
        bus.i_addr = 32'h204;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h84;
        tick();
        bus.d_req   = 1'b0;
        bus.i_addr  = 32'h208;
        bus.i_flush = 1'b1;
        #1 chk("t4_flush_i_gnt", bus.i_gnt, 1);
        chk("t4_flush_mem_en", bus.mem_en, 1);
        chk("t4_flush_i_rvalid", bus.i_rvalid, 0);
        tick();
        idle_reqs();
        repeat (LAT + 2) tick();

        // Async reset with two reads in flight.
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h10C;
        tick();
        bus.i_req  = 1'b0;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h88;
        tick();
        bus.i_req = 1'b1;
        #1 reset = 1'b1;
        #1 chk("t5_i_gnt", bus.i_gnt, 0);
        chk("t5_d_gnt", bus.d_gnt, 0);
        chk("t5_mem_en", bus.mem_en, 0);
        chk("t5_mem_addr", bus.mem_addr, 0);
        chk("t5_d_rvalid", bus.d_rvalid, 0);
        repeat (2) tick();
        idle_reqs();
        reset = 1'b0;
        repeat (LAT + 2) tick();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h300;
        #1 chk("t5_post_i_gnt", bus.i_gnt, 1);
        tick();
        idle_reqs();
        repeat (LAT + 1) tick();

        // ena low: nothing granted, earlier reads still come back.
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h110;
        tick();
        bus.i_req  = 1'b0;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h8C;
        tick();
        bus.ena   = 1'b0;
        bus.i_req = 1'b1;
        for (int k = 0; k < LAT + 1; k++) begin
            #1 chk("t6_i_gnt", bus.i_gnt, 0);
            chk("t6_d_gnt", bus.d_gnt, 0);
            chk("t6_i_stall", bus.i_stall, 1);
            tick();
        end
        idle_reqs();
        bus.ena = 1'b1;
        repeat (LAT + 1) tick();

        // Random mixed traffic.
        for (int k = 0; k < 80; k++) begin
            bus.ena     = ($urandom_range(0, 7) != 0);
            bus.i_req   = $urandom_range(0, 1);
            bus.d_req   = $urandom_range(0, 1);
            bus.d_we    = ($urandom_range(0, 3) == 0);
            bus.i_flush = ($urandom_range(0, 7) == 0);
            bus.i_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            bus.d_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            bus.d_wdata = $urandom;
            tick();
        end
        idle_reqs();
        bus.ena = 1'b1;
        repeat (LAT + 2) tick();

        chk("iq_left", iq.size(), 0);
        chk("dq_left", dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
